mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the pipeline's instruction-fetch (IF) requester and the MEM-stage load/store (D) requester.
- Sequences one transaction at a time over a variable-latency ready handshake.
- Returns read data and a one-cycle acknowledge to the winning requester, and drives stall outputs that the pipeline ORs into its PC/IF-ID write enables and EX/MEM hold.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 3, consecutive D grants while IF waits before IF is forced to win (1..15)
TIMEOUT, 15, cycles without mem_ready before abort (only with MEMARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, valid when if_ack=1
if_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid when d_ack=1
d_ack  out  1  one-cycle data completion pulse
mem_req  out  1  memory transaction valid
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current transaction this cycle
stall_if  out  1  if_req & ~if_ack (combinational)
stall_mem  out  1  d_req & ~d_ack (combinational)
bus_err  out  1  one-cycle abort pulse (MEMARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (reset=0, async): state IDLE; all registered outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_ack, d_ack, bus_err); starve_cnt=0.
- Reset asserted mid-transaction: the transaction is abandoned with no ack.
- FSM states:
  - IDLE: arbitrate on each edge.
  - BUSY_IF: fetch in flight.
  - BUSY_D: data access in flight.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant D unless starve_cnt==STARVE_MAX, in which case grant IF.
  - On grant, register mem_addr/mem_we/mem_wdata from the winner and set mem_req=1 on the next edge. For IF: mem_we=0, mem_wdata=0.
- Starve counter:
  - Increments on each D grant while if_req=1.
  - Clears on any IF grant.
  - Saturates at STARVE_MAX.
- BUSY_x:
  - mem_req and the address/data outputs are held stable until mem_ready=1 is sampled.
  - On that edge: capture mem_rdata into the winner's rdata register (loads and fetches only; stores leave d_rdata unchanged), pulse the winner's ack for exactly one cycle, drop mem_req, return to IDLE.
- Latency:
  - Request first seen high at edge N → mem_req=1 after N.
  - With zero wait states (mem_ready=1 in the first mem_req cycle), ack is high in the cycle after edge N+1.
  - Each additional wait cycle adds one.
- Back-to-back: IDLE is visited for at least one cycle between transactions. The ack cycle is the IDLE cycle, and a request still held in that cycle is not re-granted, because the requester drops it on ack. Peak throughput is therefore 1 transaction per 2 cycles.
- Requester drops req mid-transaction (protocol violation): the transaction completes and the ack still pulses.
- mem_ready while IDLE is ignored.
- rdata registers hold their last value between acks.

Optional Feature:
MEMARB_TIMEOUT_EN defined:
- A 4-bit wait counter runs in BUSY_x.
- If it reaches TIMEOUT without mem_ready: drop mem_req, pulse bus_err and the winner's ack together for one cycle, leave rdata unchanged, return to IDLE.
- The counter clears on each new grant.

MEMARB_TIMEOUT_EN undefined:
- No counter; the arbiter waits indefinitely for mem_ready.
- bus_err is constant 0.

Test Plan:
1. Reset release, if_req=1, if_addr=0x00000004, mem_ready=1, mem_rdata=0x20080005 → mem_req/mem_addr=0x4 one cycle after the request is sampled, if_ack=1 with if_rdata=0x20080005 the cycle after, stall_if=1 until then.
2. Store: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, mem_ready delayed 3 cycles → mem_we=1 and address/data stable for 4 cycles, d_ack one pulse, d_rdata unchanged.
3. if_req and d_req both held high continuously, STARVE_MAX=3, mem_ready=1 → grant order D, D, D, IF, D, D, D, IF…
4. Load in flight (BUSY_D, mem_ready=0), reset driven low → mem_req=0 and all outputs 0 immediately; after release with d_req still high, the load reissues from IDLE.
5. MEMARB_TIMEOUT_EN defined, TIMEOUT=15, mem_ready held 0 → after 15 cycles mem_req=0, bus_err=1 and if_ack=1 for exactly one cycle. Without the macro: mem_req stays 1 indefinitely and bus_err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and load/store (D).
// Optional abort-on-timeout logic is built when MEMARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              bus_err_o
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WAIT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              grant_d_c, grant_if_c, done_c;

    // D wins ties unless IF has waited through STARVE_MAX consecutive D grants
    assign grant_d_c  = d_req_i & (~if_req_i | (starve_q != STARVE_LIM));
    assign grant_if_c = if_req_i & ~grant_d_c;

`ifdef MEMARB_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              bus_err_q, bus_err_d;
    logic              timeout_c;

    assign timeout_c = (wait_q == WAIT_W'(TIMEOUT - 1)) & ~mem_ready_i;
    assign done_c    = mem_ready_i | timeout_c;
    assign bus_err_o = bus_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT);
    assign done_c         = mem_ready_i;
    assign bus_err_o      = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d_c) begin
                    state_d = BUSY_D;
                end else if (grant_if_c) begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (done_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; memory-side outputs hold unless changed
    always_comb begin
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
        wait_d      = wait_q;
        bus_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (grant_d_c) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    if (if_req_i && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
`ifdef MEMARB_TIMEOUT_EN
                    wait_d = '0;
`endif
                end else if (grant_if_c) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    starve_d    = '0;
`ifdef MEMARB_TIMEOUT_EN
                    wait_d = '0;
`endif
                end
            end
            BUSY_IF: begin
                if (mem_ready_i) begin
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata_i;
                    if_ack_d   = 1'b1;
                end
`ifdef MEMARB_TIMEOUT_EN
                else if (timeout_c) begin
                    mem_req_d = 1'b0;
                    if_ack_d  = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end
            BUSY_D: begin
                if (mem_ready_i) begin
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                end
`ifdef MEMARB_TIMEOUT_EN
                else if (timeout_c) begin
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end
            default: ;
        endcase
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign d_ack_o     = d_ack_q;

    // Stalls follow the live request so the pipeline releases in the ack cycle
    assign stall_if_o  = if_req_i & ~if_ack_q;
    assign stall_mem_o = d_req_i & ~d_ack_q;

endmodule
